// File: rtl/reg_file_pkg.sv
// Shared register-file constants: default geometry and the x0 index that
// write clients (int_div and later units) use to recognise discarded results.
package reg_file_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int NUM_REGS      = 32;
  localparam int REG_SEL_WIDTH = $clog2(NUM_REGS);

  typedef logic [REG_SEL_WIDTH-1:0] reg_sel_t;

  localparam reg_sel_t X0_SEL = '0;

endpackage

// File: rtl/reg_file_wr_responder_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at a rotating
// pointer, which moves just past the winner whenever a grant is issued.
module rr_arbiter #(
  parameter  int n         = 2,
  localparam int ptr_width = (n > 1) ? $clog2(n) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] req_i,
  input  logic         en_i,
  output logic [n-1:0] grant_o,
  output logic         valid_o
);

  logic [ptr_width-1:0] ptr_q, ptr_d;
  logic [ptr_width-1:0] idx;

  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    ptr_d   = ptr_q;
    idx     = '0;
    for (int i = 0; i < n; i++) begin
      idx = ptr_width'((int'(ptr_q) + i) % n);
      if (en_i && !valid_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        valid_o      = 1'b1;
        ptr_d        = ptr_width'((int'(idx) + 1) % n);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/reg_file_wr_responder.sv
// Integer register file: direct core writeback port plus round-robin
// arbitrated handshake clients, two combinational read ports, x0 reads zero.
module reg_file_wr_responder
  import reg_file_pkg::*;
#(
  parameter  int data_width    = DATA_WIDTH,
  parameter  int num_regs      = NUM_REGS,
  parameter  int num_clients   = 2,
  localparam int reg_sel_width = $clog2(num_regs)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 core_wr_en,
  input  logic [reg_sel_width-1:0]             core_wr_sel,
  input  logic [data_width-1:0]                core_wr_data,
  input  logic [num_clients-1:0]               rf_wr_req,
  input  logic [num_clients*reg_sel_width-1:0] rf_wr_sel,
  input  logic [num_clients*data_width-1:0]    rf_wr_data,
  output logic [num_clients-1:0]               rf_wr_ack,
  input  logic [reg_sel_width-1:0]             rd_sel_a,
  input  logic [reg_sel_width-1:0]             rd_sel_b,
  output logic [data_width-1:0]                rd_data_a,
  output logic [data_width-1:0]                rd_data_b
);

  logic [data_width-1:0]    regs_q [num_regs];
  logic [num_clients-1:0]   ack_q;
  logic [num_clients-1:0]   eligible;
  logic [num_clients-1:0]   grant;
  logic                     grant_valid;
  logic [reg_sel_width-1:0] cl_sel;
  logic [data_width-1:0]    cl_data;
  logic                     wr_en_d;
  logic [reg_sel_width-1:0] wr_sel_d;
  logic [data_width-1:0]    wr_data_d;

  // A client's req is still up during its ack cycle; masking it stops a re-grant.
  assign eligible = rf_wr_req & ~ack_q;

  rr_arbiter #(.n(num_clients)) u_arb (
    .clk     (clk),
    .rst_n   (rst),
    .req_i   (eligible),
    .en_i    (!core_wr_en),
    .grant_o (grant),
    .valid_o (grant_valid)
  );

  always_comb begin
    cl_sel  = '0;
    cl_data = '0;
    for (int k = 0; k < num_clients; k++) begin
      if (grant[k]) begin
        cl_sel  = rf_wr_sel[k*reg_sel_width +: reg_sel_width];
        cl_data = rf_wr_data[k*data_width +: data_width];
      end
    end
  end

  always_comb begin
    wr_en_d   = 1'b0;
    wr_sel_d  = '0;
    wr_data_d = '0;
    if (core_wr_en) begin
      wr_en_d   = (core_wr_sel != '0);
      wr_sel_d  = core_wr_sel;
      wr_data_d = core_wr_data;
    end else if (grant_valid) begin
      wr_en_d   = (cl_sel != '0);
      wr_sel_d  = cl_sel;
      wr_data_d = cl_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < num_regs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      regs_q[wr_sel_d] <= wr_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_q <= '0;
    end else begin
      ack_q <= grant;
    end
  end

  assign rf_wr_ack = ack_q;
  assign rd_data_a = (rd_sel_a == '0) ? '0 : regs_q[rd_sel_a];
  assign rd_data_b = (rd_sel_b == '0) ? '0 : regs_q[rd_sel_b];

endmodule

// File: tb/tb_reg_file_wr_responder.sv
// Bench for reg_file_wr_responder: directed vector table, reset corner cases,
// then randomized traffic against a behavioural model of the write protocol.
module tb_reg_file_wr_responder;

  logic        clk;
  logic        rst;
  logic        coreWrEn;
  logic [4:0]  coreWrSel;
  logic [31:0] coreWrData;
  logic [1:0]  rfWrReq;
  logic [9:0]  rfWrSel;
  logic [63:0] rfWrData;
  logic [1:0]  rfWrAck;
  logic [4:0]  rdSelA, rdSelB;
  logic [31:0] rdDataA, rdDataB;

  int checks = 0;
  int errors = 0;

  reg_file_wr_responder dut (
    .clk          (clk),
    .rst          (rst),
    .core_wr_en   (coreWrEn),
    .core_wr_sel  (coreWrSel),
    .core_wr_data (coreWrData),
    .rf_wr_req    (rfWrReq),
    .rf_wr_sel    (rfWrSel),
    .rf_wr_data   (rfWrData),
    .rf_wr_ack    (rfWrAck),
    .rd_sel_a     (rdSelA),
    .rd_sel_b     (rdSelB),
    .rd_data_a    (rdDataA),
    .rd_data_b    (rdDataB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        coreEn;
    logic [4:0]  coreSel;
    logic [31:0] coreData;
    logic [1:0]  req;
    logic [4:0]  sel0;
    logic [31:0] data0;
    logic [4:0]  sel1;
    logic [31:0] data1;
    logic [4:0]  rdA;
    logic [4:0]  rdB;
    logic [1:0]  expAck;
    logic [31:0] expA;
    logic [31:0] expB;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mkVec(logic ce, logic [4:0] cs, logic [31:0] cd, logic [1:0] rq,
                                 logic [4:0] s0, logic [31:0] d0, logic [4:0] s1, logic [31:0] d1,
                                 logic [4:0] ra, logic [4:0] rb, logic [1:0] ea,
                                 logic [31:0] xa, logic [31:0] xb);
    vec_t v;
    v.coreEn = ce; v.coreSel = cs; v.coreData = cd; v.req = rq;
    v.sel0 = s0; v.data0 = d0; v.sel1 = s1; v.data1 = d1;
    v.rdA = ra; v.rdB = rb; v.expAck = ea; v.expA = xa; v.expB = xb;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    coreWrEn   = v.coreEn;
    coreWrSel  = v.coreSel;
    coreWrData = v.coreData;
    rfWrReq    = v.req;
    rfWrSel    = {v.sel1, v.sel0};
    rfWrData   = {v.data1, v.data0};
    rdSelA     = v.rdA;
    rdSelB     = v.rdB;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Behavioural model state for the randomized phase
  logic [31:0] mRegs [32];
  logic [1:0]  mAck;
  int          mPtr;
  bit          pending [2];
  bit          stale [2];
  logic [4:0]  cSel [2];
  logic [31:0] cData [2];

  function automatic logic [31:0] mRead(logic [4:0] sel);
    return (sel == 5'd0) ? 32'd0 : mRegs[sel];
  endfunction

  initial begin
    vec_t idle;
    idle = mkVec(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    applyStimulus(idle);
    rst = 1'b0;

    vecs[0]  = mkVec(0, 0, 0,     2'b00, 3, 32'h0,    0, 32'h0,   5, 0, 2'b00, 32'h0,    32'h0);
    vecs[1]  = mkVec(0, 0, 0,     2'b01, 3, 32'h1234, 0, 32'h0,   3, 0, 2'b01, 32'h1234, 32'h0);
    vecs[2]  = mkVec(0, 0, 0,     2'b01, 3, 32'h1234, 0, 32'h0,   3, 0, 2'b00, 32'h1234, 32'h0);
    vecs[3]  = mkVec(0, 0, 0,     2'b01, 4, 32'h7,    0, 32'h0,   4, 3, 2'b01, 32'h7,    32'h1234);
    vecs[4]  = mkVec(0, 0, 0,     2'b00, 4, 32'h7,    0, 32'h0,   4, 3, 2'b00, 32'h7,    32'h1234);
    vecs[5]  = mkVec(0, 0, 0,     2'b11, 6, 32'h66,   7, 32'h77,  6, 7, 2'b10, 32'h0,    32'h77);
    vecs[6]  = mkVec(0, 0, 0,     2'b11, 6, 32'h66,   7, 32'h77,  6, 7, 2'b01, 32'h66,   32'h77);
    vecs[7]  = mkVec(0, 0, 0,     2'b11, 6, 32'h66,   7, 32'h177, 6, 7, 2'b10, 32'h66,   32'h177);
    vecs[8]  = mkVec(0, 0, 0,     2'b11, 6, 32'h166,  7, 32'h177, 6, 7, 2'b01, 32'h166,  32'h177);
    vecs[9]  = mkVec(1, 9, 32'hAA, 2'b10, 0, 32'h0,  10, 32'hBB,  9, 10, 2'b00, 32'hAA,  32'h0);
    vecs[10] = mkVec(1, 9, 32'hAA, 2'b10, 0, 32'h0,  10, 32'hBB,  9, 10, 2'b00, 32'hAA,  32'h0);
    vecs[11] = mkVec(1, 9, 32'hAA, 2'b10, 0, 32'h0,  10, 32'hBB,  9, 10, 2'b00, 32'hAA,  32'h0);
    vecs[12] = mkVec(0, 0, 0,     2'b10, 0, 32'h0,   10, 32'hBB,  9, 10, 2'b10, 32'hAA,  32'hBB);
    vecs[13] = mkVec(0, 0, 0,     2'b00, 0, 32'h0,    0, 32'h0,   9, 10, 2'b00, 32'hAA,  32'hBB);
    vecs[14] = mkVec(0, 0, 0,     2'b01, 0, 32'hFF,   0, 32'h0,   0, 9, 2'b01, 32'h0,    32'hAA);
    vecs[15] = mkVec(0, 0, 0,     2'b00, 0, 32'h0,    0, 32'h0,   0, 9, 2'b00, 32'h0,    32'hAA);
    vecs[16] = mkVec(1, 0, 32'h55, 2'b00, 0, 32'h0,   0, 32'h0,   0, 9, 2'b00, 32'h0,    32'hAA);
    vecs[17] = mkVec(0, 0, 0,     2'b01, 9, 32'h99,   0, 32'h0,   9, 10, 2'b01, 32'h99,  32'hBB);

    // Reset held, then released
    rdSelA = 5'd5;
    repeat (3) tick();
    checkOutput("reset ack", {30'd0, rfWrAck}, 32'd0);
    checkOutput("reset rd5", rdDataA, 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d ack", i), {30'd0, rfWrAck}, {30'd0, vecs[i].expAck});
      checkOutput($sformatf("vec%0d rdA", i), rdDataA, vecs[i].expA);
      checkOutput($sformatf("vec%0d rdB", i), rdDataB, vecs[i].expB);
    end

    // Reset asserted in the cycle a grant would commit
    applyStimulus(idle);
    rfWrReq = 2'b01; rfWrSel = {5'd0, 5'd12}; rfWrData = {32'd0, 32'h3C};
    rdSelA = 5'd12; rdSelB = 5'd9;
    rst = 1'b0;
    tick();
    checkOutput("rstmid ack", {30'd0, rfWrAck}, 32'd0);
    checkOutput("rstmid rd12", rdDataA, 32'd0);
    checkOutput("rstmid rd9", rdDataB, 32'd0);
    rst = 1'b1; rfWrReq = 2'b00;
    tick();
    checkOutput("rstrel ack", {30'd0, rfWrAck}, 32'd0);
    checkOutput("rstrel rd12", rdDataA, 32'd0);

    // Asynchronous reset while an ack pulse is high
    rfWrReq = 2'b10; rfWrSel = {5'd13, 5'd0}; rfWrData = {32'h5A, 32'd0};
    rdSelA = 5'd13;
    tick();
    checkOutput("preack ack", {30'd0, rfWrAck}, 32'h2);
    checkOutput("preack rd13", rdDataA, 32'h5A);
    rfWrReq = 2'b00;
    #2 rst = 1'b0;
    #1;
    checkOutput("asyncrst ack", {30'd0, rfWrAck}, 32'd0);
    checkOutput("asyncrst rd13", rdDataA, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    for (int r = 0; r < 32; r++) mRegs[r] = 32'd0;
    mAck = 2'b00;
    mPtr = 0;
    for (int k = 0; k < 2; k++) begin
      pending[k] = 0; stale[k] = 0; cSel[k] = '0; cData[k] = '0;
    end

    for (int cyc = 0; cyc < 3000; cyc++) begin
      int winner;
      for (int k = 0; k < 2; k++) begin
        if (mAck[k]) begin
          pending[k] = 0;
          stale[k]   = bit'($urandom_range(0, 1));
        end else begin
          stale[k] = 0;
          if (pending[k] && $urandom_range(0, 19) == 0) begin
            pending[k] = 0;
          end else if (!pending[k] && $urandom_range(0, 1) == 1) begin
            pending[k] = 1;
            cSel[k]    = 5'($urandom_range(0, 31));
            cData[k]   = $urandom;
          end
        end
      end
      rfWrReq    = {pending[1] | stale[1], pending[0] | stale[0]};
      rfWrSel    = {cSel[1], cSel[0]};
      rfWrData   = {cData[1], cData[0]};
      coreWrEn   = ($urandom_range(0, 4) == 0);
      coreWrSel  = 5'($urandom_range(0, 31));
      coreWrData = $urandom;
      rdSelA     = 5'($urandom_range(0, 31));
      rdSelB     = 5'($urandom_range(0, 31));

      // Model: core wins; otherwise first unacked requester from the pointer
      winner = -1;
      if (!coreWrEn) begin
        for (int i = 0; i < 2; i++) begin
          int k;
          k = (mPtr + i) % 2;
          if (winner < 0 && rfWrReq[k] && !mAck[k]) winner = k;
        end
      end
      if (coreWrEn) begin
        if (coreWrSel != 5'd0) mRegs[coreWrSel] = coreWrData;
      end else if (winner >= 0) begin
        if (cSel[winner] != 5'd0) mRegs[cSel[winner]] = cData[winner];
      end
      mAck = 2'b00;
      if (winner >= 0) begin
        mAck[winner] = 1'b1;
        mPtr = (winner + 1) % 2;
      end

      tick();
      checkOutput($sformatf("rand%0d ack", cyc), {30'd0, rfWrAck}, {30'd0, mAck});
      checkOutput($sformatf("rand%0d rdA", cyc), rdDataA, mRead(rdSelA));
      checkOutput($sformatf("rand%0d rdB", cyc), rdDataB, mRead(rdSelB));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
